// File: rtl/fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// fifo_serial_tx
//
// Read-side consumer for the synchronous FIFO. Pops one word at a time and
// sends it on a single serial line as: start bit (0), WIDTH data bits LSB
// first, optional even-parity bit, stop bit (1). A new word is popped only
// from IDLE or at the end of a stop bit, so frames run back-to-back with a
// two-cycle gap (POP, LOAD) when the FIFO stays non-empty.
//
// Parameters
//   WIDTH     data word width (must match the FIFO)
//   BAUD_DIV  clk cycles per serial bit, 1..1024
//
// Ports
//   i_clk            rising-edge clock
//   i_rst_           synchronous active-high reset
//   i_tx_en          permits new frames; a running frame always completes
//   i_fifo_data_out  FIFO read data, valid the cycle after o_fifo_read
//   i_fifo_empty     FIFO empty flag
//   o_fifo_read      one-cycle pop strobe
//   o_tx_serial      serial line, idles high
//   o_tx_busy        high in every state except IDLE
//   o_tx_done        one-cycle pulse after the last stop-bit cycle
//
// Build option
//   FIFO_SERIAL_TX_PARITY_EN  inserts an even-parity bit between the data
//                             bits and the stop bit
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for tx_en and a non-empty FIFO
// POP    | fifo_read asserted for this single cycle
// LOAD   | FIFO data is valid; capture it into the shift register
// START  | start bit (line low) for BAUD_DIV cycles
// DATA   | shift register LSB on the line, one bit per BAUD_DIV cycles
// PARITY | even parity of the captured word (parity build only)
// STOP   | stop bit (line high) for BAUD_DIV cycles
// -----------------------------------------------------------------------------
module fifo_serial_tx #(
   parameter int WIDTH    = 16,
   parameter int BAUD_DIV = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_,
   input  logic             i_tx_en,
   input  logic [WIDTH-1:0] i_fifo_data_out,
   input  logic             i_fifo_empty,
   output logic             o_fifo_read,
   output logic             o_tx_serial,
   output logic             o_tx_busy,
   output logic             o_tx_done
);

   localparam int BC_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH + 1);

   localparam logic [BC_W-1:0]  BAUD_LAST = BC_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [BC_W-1:0]  r_baud;
   logic [BIT_W-1:0] r_bit;
   logic             r_fifo_read;
   logic             r_tx_serial;
   logic             r_tx_busy;
   logic             r_tx_done;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   logic             r_parity;
`endif

   logic             w_baud_tc;
   logic [BC_W-1:0]  w_baud_nxt;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             w_start_ok;

   // With BAUD_DIV=1 the counter stays at 0 and every cycle is terminal.
   assign w_baud_tc   = (r_baud == BAUD_LAST);
   assign w_baud_nxt  = w_baud_tc ? '0 : r_baud + BC_W'(1);
   assign w_shift_nxt = r_shift >> 1;
   assign w_start_ok  = i_tx_en & ~i_fifo_empty;

   // Outputs are registered alongside the state so each one reflects the
   // state being entered on the same edge.
   always_ff @(posedge i_clk) begin
      if (i_rst_) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_baud      <= '0;
         r_bit       <= '0;
         r_fifo_read <= 1'b0;
         r_tx_serial <= 1'b1;
         r_tx_busy   <= 1'b0;
         r_tx_done   <= 1'b0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
         r_parity    <= 1'b0;
`endif
      end else begin
         r_fifo_read <= 1'b0;
         r_tx_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tx_serial <= 1'b1;
               if (w_start_ok) begin
                  r_state     <= S_POP;
                  r_fifo_read <= 1'b1;
                  r_tx_busy   <= 1'b1;
               end
            end
            S_POP: begin
               r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_shift     <= i_fifo_data_out;
`ifdef FIFO_SERIAL_TX_PARITY_EN
               r_parity    <= ^i_fifo_data_out;
`endif
               r_baud      <= '0;
               r_tx_serial <= 1'b0;
               r_state     <= S_START;
            end
            S_START: begin
               r_baud <= w_baud_nxt;
               if (w_baud_tc) begin
                  r_state     <= S_DATA;
                  r_bit       <= '0;
                  r_tx_serial <= r_shift[0];
               end
            end
            S_DATA: begin
               r_baud <= w_baud_nxt;
               if (w_baud_tc) begin
                  r_shift <= w_shift_nxt;
                  r_bit   <= r_bit + BIT_W'(1);
                  if (r_bit == BIT_LAST) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                     r_state     <= S_PARITY;
                     r_tx_serial <= r_parity;
`else
                     r_state     <= S_STOP;
                     r_tx_serial <= 1'b1;
`endif
                  end else begin
                     r_tx_serial <= w_shift_nxt[0];
                  end
               end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            S_PARITY: begin
               r_baud <= w_baud_nxt;
               if (w_baud_tc) begin
                  r_state     <= S_STOP;
                  r_tx_serial <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               r_baud <= w_baud_nxt;
               if (w_baud_tc) begin
                  r_tx_done <= 1'b1;
                  // Back-to-back: pop the next word without passing through IDLE.
                  if (w_start_ok) begin
                     r_state     <= S_POP;
                     r_fifo_read <= 1'b1;
                  end else begin
                     r_state   <= S_IDLE;
                     r_tx_busy <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_tx_serial <= 1'b1;
               r_tx_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign o_fifo_read = r_fifo_read;
   assign o_tx_serial = r_tx_serial;
   assign o_tx_busy   = r_tx_busy;
   assign o_tx_done   = r_tx_done;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_serial_tx
//
// Directed bench for fifo_serial_tx (WIDTH=16, BAUD_DIV=4). A small array-based
// FIFO model answers pops on the falling edge; all DUT outputs are sampled on
// the falling edge. Frame contents are compared bit-by-bit against the words
// pushed by the bench.
// -----------------------------------------------------------------------------
module tb_fifo_serial_tx;

   localparam int WIDTH = 16;
   localparam int BAUD  = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME = (WIDTH + 2 + PAR) * BAUD;

   logic              clk   = 1'b0;
   logic              rst_  = 1'b1;
   logic              tx_en = 1'b0;
   logic [WIDTH-1:0]  fifo_dout = '0;
   logic              fifo_empty;
   logic              o_read;
   logic              o_ser;
   logic              o_busy;
   logic              o_done;

   logic [WIDTH-1:0]  mem [64];
   int                wr_ptr = 0;
   int                rd_ptr = 0;
   int                n_uflow = 0;
   int                n_dbl = 0;
   logic              prev_read = 1'b0;

   int                n_tests = 0;
   int                n_fail  = 0;

   fifo_serial_tx #(.WIDTH(WIDTH), .BAUD_DIV(BAUD)) dut (
      .i_clk           (clk),
      .i_rst_          (rst_),
      .i_tx_en         (tx_en),
      .i_fifo_data_out (fifo_dout),
      .i_fifo_empty    (fifo_empty),
      .o_fifo_read     (o_read),
      .o_tx_serial     (o_ser),
      .o_tx_busy       (o_busy),
      .o_tx_done       (o_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   // FIFO model: data for a pop is presented before the following rising edge.
   always @(negedge clk) begin
      if (o_read) begin
         if (rd_ptr == wr_ptr) n_uflow++;
         else begin
            fifo_dout = mem[rd_ptr];
            rd_ptr++;
         end
         if (prev_read) n_dbl++;
      end
      prev_read = o_read;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [WIDTH-1:0] w);
      mem[wr_ptr] = w;
      wr_ptr++;
   endtask

   // Waits up to budget falling edges for a pop strobe.
   task automatic wait_read(input string tag, input int budget);
      int found = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (o_read) begin
            found = 1;
            break;
         end
      end
      chk({tag, " pop seen"}, 32'(found), 32'd1);
   endtask

   // From the POP cycle: one LOAD cycle with the line high, then the start bit.
   task automatic pop_to_start(input string tag);
      @(negedge clk);
      chk({tag, " load"}, 32'({o_ser, o_read}), 32'b10);
      @(negedge clk);
      chk({tag, " start"}, 32'(o_ser), 32'd0);
   endtask

   // Called on the first start-bit cycle; ends on the cycle after the frame.
   task automatic frame_check(input string tag, input logic [WIDTH-1:0] word, input int drop_at);
      int bad = 0;
      int seg;
      logic e;
      logic [WIDTH-1:0] obs = '0;
      logic pbit = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         if (k > 0) @(negedge clk);
         if (k == drop_at) tx_en = 1'b0;
         seg = k / BAUD;
         if (seg == 0) e = 1'b0;
         else if (seg <= WIDTH) e = word[seg-1];
         else if (PAR == 1 && seg == WIDTH + 1) e = ^word;
         else e = 1'b1;
         if (o_ser !== e || o_read !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) bad++;
         if ((k % BAUD) == BAUD / 2 && seg >= 1 && seg <= WIDTH) obs[seg-1] = o_ser;
         if ((k % BAUD) == BAUD / 2 && seg == WIDTH + 1) pbit = o_ser;
      end
      chk({tag, " line cycles wrong"}, 32'(bad), 32'd0);
      chk({tag, " data"}, 32'(obs), 32'(word));
`ifdef FIFO_SERIAL_TX_PARITY_EN
      chk({tag, " parity"}, 32'(pbit), 32'(^word));
`endif
      @(negedge clk);
      chk({tag, " done"}, 32'(o_done), 32'd1);
   endtask

   initial begin
      int c_rd, c_low, c_busy;
      logic [WIDTH-1:0] words3 [3];
      words3[0] = 16'h8001;
      words3[1] = 16'h00FF;
      words3[2] = 16'h5A5A;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst serial", 32'(o_ser), 32'd1);
      chk("rst read",   32'(o_read), 32'd0);
      chk("rst busy",   32'(o_busy), 32'd0);
      chk("rst done",   32'(o_done), 32'd0);
      rst_  = 1'b0;
      tx_en = 1'b1;

      // 1: empty FIFO, nothing happens
      c_rd = 0; c_low = 0; c_busy = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (o_read) c_rd++;
         if (!o_ser) c_low++;
         if (o_busy) c_busy++;
      end
      chk("t1 reads", 32'(c_rd), 32'd0);
      chk("t1 line low", 32'(c_low), 32'd0);
      chk("t1 busy", 32'(c_busy), 32'd0);

      // 2: single word
      push(16'hA5C3);
      wait_read("t2", 5);
      pop_to_start("t2");
      frame_check("t2", 16'hA5C3, -1);
      chk("t2 busy after", 32'(o_busy), 32'd0);
      chk("t2 no repop", 32'(o_read), 32'd0);
      @(negedge clk);
      chk("t2 done single", 32'(o_done), 32'd0);

      // 3: three words back-to-back
      for (int i = 0; i < 3; i++) push(words3[i]);
      wait_read("t3", 5);
      for (int i = 0; i < 3; i++) begin
         pop_to_start($sformatf("t3.%0d", i));
         frame_check($sformatf("t3.%0d", i), words3[i], -1);
         chk($sformatf("t3.%0d next pop", i), 32'(o_read), 32'(i < 2));
         chk($sformatf("t3.%0d busy", i), 32'(o_busy), 32'(i < 2));
      end

      // 4: tx_en dropped mid-DATA with a second word queued
      @(negedge clk);
      push(16'h1357);
      push(16'hC0DE);
      wait_read("t4", 5);
      pop_to_start("t4");
      frame_check("t4", 16'h1357, 30);
      chk("t4 no pop at end", 32'(o_read), 32'd0);
      c_rd = 0; c_low = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_read) c_rd++;
         if (!o_ser) c_low++;
      end
      chk("t4 held reads", 32'(c_rd), 32'd0);
      chk("t4 held line low", 32'(c_low), 32'd0);
      tx_en = 1'b1;
      wait_read("t4 resume", 3);
      pop_to_start("t4 resume");
      frame_check("t4 resume", 16'hC0DE, -1);

      // 5: reset pulse in DATA
      @(negedge clk);
      push(16'hFFFF);
      push(16'h6B2D);
      wait_read("t5", 5);
      pop_to_start("t5");
      repeat (12) @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
      chk("t5 rst serial", 32'(o_ser), 32'd1);
      chk("t5 rst busy",   32'(o_busy), 32'd0);
      chk("t5 rst read",   32'(o_read), 32'd0);
      chk("t5 rst done",   32'(o_done), 32'd0);
      rst_ = 1'b0;
      wait_read("t5 after", 2);
      pop_to_start("t5 after");
      frame_check("t5 after", 16'h6B2D, -1);

      // 6: parity boundary words (parity bit checked in parity build)
      @(negedge clk);
      push(16'h0001);
      wait_read("t6a", 5);
      pop_to_start("t6a");
      frame_check("t6a", 16'h0001, -1);
      @(negedge clk);
      push(16'h0003);
      wait_read("t6b", 5);
      pop_to_start("t6b");
      frame_check("t6b", 16'h0003, -1);

      repeat (3) @(negedge clk);
      chk("fifo underflow reads", 32'(n_uflow), 32'd0);
      chk("consecutive reads", 32'(n_dbl), 32'd0);
      chk("fifo drained", 32'(rd_ptr), 32'(wr_ptr));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
